// File: rtl/sw_debounce_pkg.sv
// Shared state encoding and default timing constants for the switch debouncer.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    DISARM = 2'd3
  } state_t;

  localparam int DEF_DEB_CYCLES = 500000;
  localparam int DEF_REP_DELAY  = 25000000;
  localparam int DEF_REP_PERIOD = 5000000;
  localparam int DEF_CNT_W      = 25;

  // True when a count of 'value' can be represented in a 'width'-bit timer.
  function automatic bit fits_cnt(input int value, input int width);
    return longint'(value) < (longint'(1) << width);
  endfunction

endpackage

// File: rtl/sw_sync2.sv
// Two-flop synchronizer for the asynchronous switch input, synchronous reset to 0.
module sw_sync2 (
  input  logic CLOCK,
  input  logic RESET,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/sw_debounce_pulse.sv
// Switch debouncer producing one enable pulse per accepted press.
// Optional auto-repeat while held is enabled by defining SW_DEBOUNCE_AUTO_REPEAT_EN.
module sw_debounce_pulse
  import sw_debounce_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic SW_IN,
  output logic PULSE,
  output logic LEVEL
);

  if (DEB_CYCLES < 2 || !fits_cnt(DEB_CYCLES, CNT_W) ||
      REP_DELAY < 2 || !fits_cnt(REP_DELAY, CNT_W) ||
      REP_PERIOD < 2 || !fits_cnt(REP_PERIOD, CNT_W)) begin : g_bad_params
    $error("sw_debounce_pulse: illegal timing parameters for CNT_W");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s_sw;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmr, tmr_nxt, tmr_inc;
  logic             fire, fire_nxt;

  sw_sync2 u_sync (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .async_in (SW_IN),
    .sync_out (s_sw)
  );

  assign tmr_inc = (tmr == '1) ? tmr : tmr + CNT_W'(1);

`ifdef SW_DEBOUNCE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REP_PERIOD - 1);
  logic rep_phase, rep_phase_nxt;
`endif

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    fire_nxt  = 1'b0;
`ifdef SW_DEBOUNCE_AUTO_REPEAT_EN
    rep_phase_nxt = rep_phase;
`endif
    unique case (state)
      IDLE: begin
        tmr_nxt = '0;
        if (s_sw) begin
          state_nxt = ARM;
          tmr_nxt   = CNT_W'(1);
        end
      end
      // A drop on the terminal-count cycle still wins over acceptance.
      ARM: begin
        if (!s_sw) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end else if (tmr == DEB_LAST) begin
          state_nxt = HELD;
          tmr_nxt   = '0;
          fire_nxt  = 1'b1;
        end else begin
          tmr_nxt = tmr_inc;
        end
      end
      HELD: begin
        if (!s_sw) begin
          state_nxt = DISARM;
          tmr_nxt   = CNT_W'(1);
`ifdef SW_DEBOUNCE_AUTO_REPEAT_EN
          rep_phase_nxt = 1'b0;
        end else if (!rep_phase) begin
          if (tmr == DELAY_LAST) begin
            tmr_nxt       = '0;
            fire_nxt      = 1'b1;
            rep_phase_nxt = 1'b1;
          end else begin
            tmr_nxt = tmr_inc;
          end
        end else if (tmr == PERIOD_LAST) begin
          tmr_nxt  = '0;
          fire_nxt = 1'b1;
        end else begin
          tmr_nxt = tmr_inc;
        end
`else
        end else begin
          tmr_nxt = '0;
        end
`endif
      end
      DISARM: begin
        if (s_sw) begin
          state_nxt = HELD;
          tmr_nxt   = '0;
        end else if (tmr == DEB_LAST) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered decodes of the state register, one edge behind it.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      tmr   <= '0;
      fire  <= 1'b0;
      PULSE <= 1'b0;
      LEVEL <= 1'b0;
`ifdef SW_DEBOUNCE_AUTO_REPEAT_EN
      rep_phase <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      fire  <= fire_nxt;
      PULSE <= fire;
      LEVEL <= (state == HELD) || (state == DISARM);
`ifdef SW_DEBOUNCE_AUTO_REPEAT_EN
      rep_phase <= rep_phase_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sw_debounce_pulse.sv
// Directed self-checking bench for sw_debounce_pulse (DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3).
module tb_sw_debounce_pulse;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic SW_IN = 1'b0;
  logic PULSE;
  logic LEVEL;

  int checks = 0;
  int errors = 0;
  int pulse_count;

  sw_debounce_pulse #(
    .DEB_CYCLES (4),
    .REP_DELAY  (10),
    .REP_PERIOD (3),
    .CNT_W      (8)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .SW_IN (SW_IN),
    .PULSE (PULSE),
    .LEVEL (LEVEL)
  );

  always #5 CLOCK = ~CLOCK;

  // Drive inputs on the falling edge, let one rising edge sample them, return on the next falling edge.
  task automatic applyStimulus(input logic sw, input logic rst);
    SW_IN = sw;
    RESET = rst;
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic exp_pulse, input logic exp_level);
    checks++;
    assert (PULSE === exp_pulse) else begin
      errors++;
      $error("[TB] FAIL %s[%0d] PULSE observed %b expected %b", tag, idx, PULSE, exp_pulse);
    end
    checks++;
    assert (LEVEL === exp_level) else begin
      errors++;
      $error("[TB] FAIL %s[%0d] LEVEL observed %b expected %b", tag, idx, LEVEL, exp_level);
    end
  endtask

  initial begin
    @(negedge CLOCK);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset", 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle", i, 1'b0, 1'b0);
    end

    // Clean press: first sampled high at index 0, accepted at index 6.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("clean_press", i, i == 6, i >= 6);
    end

    // 3-cycle low glitch while held; its rise lands on DISARM's terminal count and wins.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i >= 3, 1'b0);
      checkOutput("low_glitch", i, 1'b0, 1'b1);
    end

    // Release: LEVEL falls 6 edges after the first low sample, never a pulse.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("release", i, 1'b0, i < 6);
    end

    // 3-cycle high glitch from idle; the drop lands on ARM's terminal count and wins.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i < 3, 1'b0);
      checkOutput("high_glitch", i, 1'b0, 1'b0);
    end

    // Bouncy press 1,0,1,0 then held: final rise sampled at index 4, pulse at 10.
    for (int i = 0; i < 14; i++) begin
      applyStimulus((i >= 4) || (i % 2 == 0), 1'b0);
      checkOutput("bouncy_press", i, i == 10, i >= 10);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("bouncy_release", i, 1'b0, i < 6);
    end

    // Reset mid-ARM at index 4 and mid-HELD at index 15 with the switch held throughout.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, (i == 4) || (i == 15));
      checkOutput("reset_mid", i, (i == 11) || (i == 22), ((i >= 11) && (i < 15)) || (i >= 22));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("reset_release", i, 1'b0, i < 6);
    end

    // Hold for 40 cycles, then release.
    pulse_count = 0;
    for (int i = 0; i < 52; i++) begin
      logic exp_p;
      applyStimulus(i < 40, 1'b0);
`ifdef SW_DEBOUNCE_AUTO_REPEAT_EN
      exp_p = (i == 6) || ((i >= 16) && (i <= 40) && ((i - 16) % 3 == 0));
`else
      exp_p = (i == 6);
`endif
      if (PULSE === 1'b1) pulse_count++;
      checkOutput("long_hold", i, exp_p, (i >= 6) && (i < 46));
    end
    checks++;
`ifdef SW_DEBOUNCE_AUTO_REPEAT_EN
    assert (pulse_count === 10) else begin
      errors++;
      $error("[TB] FAIL long_hold_count observed %0d expected %0d", pulse_count, 10);
    end
`else
    assert (pulse_count === 1) else begin
      errors++;
      $error("[TB] FAIL long_hold_count observed %0d expected %0d", pulse_count, 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce_pulse.md
# sw_debounce_pulse

Debounces a raw mechanical push-switch input and converts each debounced press into a single-cycle enable pulse. It sits directly upstream of the BCD down-counter, and its `PULSE` output drives the counter's `EN`: one press yields one decrement. An optional auto-repeat mode emits further pulses while the switch is held.

## Interface
- `DEB_CYCLES`, default 500000: number of consecutive stable synchronized samples required to accept a level change. Minimum 2.
- `REP_DELAY`, default 25000000: cycles in HELD before the first repeat pulse. Used only with auto-repeat.
- `REP_PERIOD`, default 5000000: cycles between subsequent repeat pulses. Used only with auto-repeat.
- `CNT_W`, default 25: timer width. Must hold max(DEB_CYCLES, REP_DELAY, REP_PERIOD).
- `CLOCK` input, 1 bit: the single clock. All logic is on its rising edge.
- `RESET` input, 1 bit: synchronous, active-high reset.
- `SW_IN` input, 1 bit: raw switch level, asynchronous to `CLOCK`. Active-high (1 = pressed).
- `PULSE` output, 1 bit: registered one-cycle enable pulse. Connects to the down-counter's `EN`.
- `LEVEL` output, 1 bit: registered debounced switch level.

## Operation
- Synchronizer: a two-flop chain produces `s_sw`, which is `SW_IN` delayed by 2 cycles. Only `s_sw` is used downstream of the chain.
- The state machine has 4 states and one timer `tmr`:
  - IDLE (`LEVEL`=0):
    - `s_sw`=1: go to ARM, `tmr`=1.
  - ARM (`LEVEL`=0):
    - `s_sw`=0: go to IDLE, `tmr`=0.
    - `tmr`==DEB_CYCLES-1: go to HELD, `LEVEL`<=1, `PULSE`<=1, `tmr`=0.
    - Otherwise: `tmr`++.
  - HELD (`LEVEL`=1):
    - `s_sw`=0: go to DISARM, `tmr`=1.
    - Otherwise: repeat logic applies (see Configuration).
  - DISARM (`LEVEL`=1):
    - `s_sw`=1: go back to HELD, `tmr`=0, no pulse.
    - `tmr`==DEB_CYCLES-1: go to IDLE, `LEVEL`<=0.
    - Otherwise: `tmr`++.
- `PULSE` is high for exactly one cycle per accepted press, and per repeat. It is never high on two consecutive cycles.
- A release never produces a pulse.
- A bounce shorter than DEB_CYCLES samples in ARM or DISARM restarts debouncing from the entry state. Such a bounce has no effect on the outputs.
- The timer saturates and never wraps. Parameter rules guarantee terminal counts are reachable.

## Timing
- Reset values: `PULSE`=0, `LEVEL`=0, state=IDLE, `tmr`=0, both synchronizer flops=0.
- `RESET` overrides everything on the same edge.
- Reset mid-ARM, mid-HELD or mid-DISARM: the next cycle is IDLE with both outputs 0. No pulse is emitted, even if a pulse was due that edge.
- Press latency:
  - Let `SW_IN` be first sampled high at edge E and held high.
  - `PULSE` and `LEVEL` rise at edge E+DEB_CYCLES+2.
  - `PULSE` falls one edge later.
- Release latency: `LEVEL` falls DEB_CYCLES+2 edges after `SW_IN` is first sampled low and held low.
- Simultaneous events:
  - If `s_sw` drops on the same cycle `tmr` hits its terminal count in ARM, the drop wins: go to IDLE, no pulse.
  - The same rule applies in DISARM: the rise wins, and the block returns to HELD.

## Configuration
- Controlled by `SW_DEBOUNCE_AUTO_REPEAT_EN`.
- Macro defined:
  - In HELD, `tmr` counts while `s_sw`=1.
  - At `tmr`==REP_DELAY-1, `PULSE` is asserted and `tmr`=0, entering repeat phase.
  - In the repeat phase, a pulse fires at every `tmr`==REP_PERIOD-1.
  - Leaving HELD clears the repeat phase.
- Macro undefined:
  - HELD holds `tmr` at 0.
  - Exactly one pulse is produced per press, regardless of hold time.
  - REP_DELAY and REP_PERIOD are unused, and no repeat logic is synthesized.

## Structure
- Shared package `sw_debounce_pkg` holds:
  - The state encoding constants IDLE=2'd0, ARM=2'd1, HELD=2'd2, DISARM=2'd3.
  - The default timing constants, so the top level and the bench share them.
- One natural sub-module, `sw_sync2`: the two-flop synchronizer. It has synchronous reset to 0.
- The state machine and timer stay in the top module.

## Test plan
All scenarios use DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3.

- Clean press: `SW_IN` rises at edge 10 and is held. `PULSE`=1 only at edge 16; `LEVEL`=1 from edge 16.
- Bouncy press: `SW_IN` toggles 1,0,1,0 on successive cycles, then is held at 1. Exactly one pulse occurs, 6 edges after the final rise is sampled.
- Glitches: a 3-cycle high on `SW_IN` from IDLE, and a 3-cycle low on `SW_IN` from HELD. In both cases there is no `PULSE` and no `LEVEL` change.
- Release: after an accepted press, `SW_IN` falls at edge 40. `LEVEL`=0 at edge 46 and no pulse occurs.
- Reset mid-ARM: `RESET` is asserted 2 cycles after `s_sw` rises. Both outputs stay 0, and a fresh press after reset is again accepted with +6 latency.
- Auto-repeat: with the macro defined, hold the switch for 40 cycles. Pulses occur at acceptance, then +10, then every +3 until release. With the macro undefined, exactly one pulse occurs.
